// File: rtl/card_pile_store_if.sv
// Command, response and status signals of card_pile_store.
// The game-control side uses master; the store itself uses slave.
interface card_pile_store_if #(
  parameter int ADDR_W  = 6,
  parameter int PILES   = 4,
  parameter int PILE_W  = 2,
  parameter int VALUE_W = 4,
  parameter int SUIT_W  = 2
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [PILE_W-1:0]  cmd_pile;
  logic [PILE_W-1:0]  cmd_dst;
  logic [VALUE_W-1:0] value;
  logic [SUIT_W-1:0]  suit;
  logic               rsp_valid;
  logic               rsp_error;
  logic [VALUE_W-1:0] rsp_value;
  logic [SUIT_W-1:0]  rsp_suit;
  logic [PILES-1:0]   pile_empty;
  logic [ADDR_W:0]    free_count;

  modport master (
    output cmd_valid, cmd_op, cmd_pile, cmd_dst, value, suit,
    input  cmd_ready, rsp_valid, rsp_error, rsp_value, rsp_suit, pile_empty, free_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_pile, cmd_dst, value, suit,
    output cmd_ready, rsp_valid, rsp_error, rsp_value, rsp_suit, pile_empty, free_count
  );
endinterface

// File: rtl/card_pile_store.sv
// Linked-list card pool holding PILES independent piles plus a free list.
// Each command is accepted in IDLE, executed in one EXEC cycle, and answered with a one-cycle response.
module card_pile_store #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int PILES   = 4,
  parameter int PILE_W  = 2,
  parameter int VALUE_W = 4,
  parameter int SUIT_W  = 2
) (
  input logic              clock,
  input logic              reset,
  card_pile_store_if.slave bus
);

  typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_PEEK = 2'b10, OP_MOVE = 2'b11} op_e;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC} state_e;
  typedef struct packed {
    logic [SUIT_W-1:0]  suit;
    logic [VALUE_W-1:0] value;
  } card_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  card_t             card_mem [DEPTH];
  logic [ADDR_W-1:0] next_mem [DEPTH];
  logic [ADDR_W-1:0] head_q   [PILES];
  logic [ADDR_W:0]   cnt_q    [PILES];
  logic [ADDR_W-1:0] free_head_q;
  logic [ADDR_W:0]   free_cnt_q;
  logic [ADDR_W-1:0] init_idx_q;

  op_e               op_q;
  logic [PILE_W-1:0] pile_q, dst_q;
  card_t             card_q;
  card_t             rsp_card_q;
  logic              rsp_valid_q, rsp_error_q;

  logic [ADDR_W-1:0] src_head, dst_head, top_next, free_next;
  card_t             top_card;
  logic              cmd_err, init_done, cmd_ready;
  logic              card_we, next_we;
  logic [ADDR_W-1:0] mem_addr, next_wdata;
  logic [PILES-1:0]  empty;

  // Operands of the latched command, read straight from the current pointers.
  always_comb begin
    src_head  = head_q[pile_q];
    dst_head  = head_q[dst_q];
    top_card  = card_mem[src_head];
    top_next  = next_mem[src_head];
    free_next = next_mem[free_head_q];
    init_done = (init_idx_q == LAST_IDX);
    cmd_err   = (op_q == OP_PUSH) ? (free_cnt_q == '0) : (cnt_q[pile_q] == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    state_d    = state_q;
    cmd_ready  = 1'b0;
    card_we    = 1'b0;
    next_we    = 1'b0;
    mem_addr   = init_idx_q;
    next_wdata = init_idx_q + ADDR_ONE;
    unique case (state_q)
      S_INIT: begin
        next_we = 1'b1;
        if (init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        if (!cmd_err) begin
          unique case (op_q)
            OP_PUSH: begin
              mem_addr   = free_head_q;
              card_we    = 1'b1;
              next_we    = 1'b1;
              next_wdata = src_head;
            end
            OP_POP: begin
              mem_addr   = src_head;
              next_we    = 1'b1;
              next_wdata = free_head_q;
            end
            OP_MOVE: begin
              mem_addr   = src_head;
              next_we    = (pile_q != dst_q);
              next_wdata = dst_head;
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: the pool is deliberately not reset; INIT rebuilds every next pointer and cards are written before being read.
  always_ff @(posedge clock) begin
    if (card_we) card_mem[mem_addr] <= card_q;
    if (next_we) next_mem[mem_addr] <= next_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < PILES; p++) begin
        head_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
      free_head_q <= '0;
      free_cnt_q  <= '0;
      init_idx_q  <= '0;
      op_q        <= OP_PUSH;
      pile_q      <= '0;
      dst_q       <= '0;
      card_q      <= '0;
      rsp_card_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          init_idx_q <= init_idx_q + ADDR_ONE;
          if (init_done) begin
            free_head_q <= '0;
            free_cnt_q  <= FULL_CNT;
          end
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q         <= op_e'(bus.cmd_op);
            pile_q       <= bus.cmd_pile;
            dst_q        <= bus.cmd_dst;
            card_q.value <= bus.value;
            card_q.suit  <= bus.suit;
          end
        end
        S_EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= cmd_err;
          if (cmd_err) begin
            rsp_card_q <= '0;
          end else begin
            unique case (op_q)
              OP_PUSH: begin
                rsp_card_q     <= card_q;
                head_q[pile_q] <= free_head_q;
                cnt_q[pile_q]  <= cnt_q[pile_q] + CNT_ONE;
                free_head_q    <= free_next;
                free_cnt_q     <= free_cnt_q - CNT_ONE;
              end
              OP_POP: begin
                rsp_card_q     <= top_card;
                head_q[pile_q] <= top_next;
                cnt_q[pile_q]  <= cnt_q[pile_q] - CNT_ONE;
                free_head_q    <= src_head;
                free_cnt_q     <= free_cnt_q + CNT_ONE;
              end
              OP_PEEK: rsp_card_q <= top_card;
              OP_MOVE: begin
                rsp_card_q <= top_card;
                // Moving a pile onto itself only reports its top card.
                if (pile_q != dst_q) begin
                  head_q[pile_q] <= top_next;
                  head_q[dst_q]  <= src_head;
                  cnt_q[pile_q]  <= cnt_q[pile_q] - CNT_ONE;
                  cnt_q[dst_q]   <= cnt_q[dst_q] + CNT_ONE;
                end
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    empty = '0;
    for (int p = 0; p < PILES; p++) empty[p] = (cnt_q[p] == '0);
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.rsp_value  = rsp_card_q.value;
  assign bus.rsp_suit   = rsp_card_q.suit;
  assign bus.pile_empty = empty;
  assign bus.free_count = free_cnt_q;

endmodule
